// File: rtl/cordic_mag_phase_if.sv
// cordic_mag_phase_if: sample-in / result-out handshake bundle for the
// vectoring CORDIC. The master side is whoever feeds samples and consumes
// results; the slave side is the CORDIC block itself.
interface cordic_mag_phase_if #(
    parameter int gp_xy_width = 12,
    parameter int gp_z_width  = 12
);
    logic                          i_valid;
    logic                          o_ready;
    logic signed [gp_xy_width-1:0] i_x;
    logic signed [gp_xy_width-1:0] i_y;
    logic                          o_valid;
    logic                          i_ready;
    logic signed [gp_xy_width+1:0] o_mag;
    logic signed [gp_z_width-1:0]  o_phase;

    modport master (
        output i_valid, i_x, i_y, i_ready,
        input  o_ready, o_valid, o_mag, o_phase
    );

    modport slave (
        input  i_valid, i_x, i_y, i_ready,
        output o_ready, o_valid, o_mag, o_phase
    );
endinterface

// File: rtl/cordic_mag_phase.sv
// cordic_mag_phase: iterative vectoring-mode CORDIC, (x,y) -> (|v|, atan2(y,x)).
// One shared add/shift datapath, one micro-rotation per enabled cycle.
// Left-half-plane inputs are pre-rotated by pi so the iterations only ever
// have to cover +-pi/2. Phase is a signed binary angle (2^gp_z_width = 2*pi).
// Optional macro CORDIC_MAG_GAIN_COMP_EN adds a one-cycle GAIN state that
// removes the CORDIC gain K from the magnitude; without it o_mag = K*|v|.
module cordic_mag_phase #(
    parameter int gp_nr_iter  = 12,
    parameter int gp_xy_width = 12,
    parameter int gp_z_width  = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_an,
    input  logic                  i_ena,
    cordic_mag_phase_if.slave     bus
);

    // Guard bits: +2 covers sqrt(2)*K growth, the low bits keep the
    // truncation error of the shifts below the output LSB.
    localparam int C_SH    = $clog2(gp_nr_iter);
    localparam int C_W_INT = gp_xy_width + 2 + C_SH;
    localparam int C_CW    = (C_SH < 1) ? 1 : C_SH;
    localparam int C_TAB   = 2 ** C_CW;
    localparam logic [gp_z_width-1:0] C_PI = {1'b1, {(gp_z_width-1){1'b0}}};

    // atan(2^-i) as a binary angle, rounded; evaluated at elaboration only.
    function automatic int atan_entry(input int i);
        real a;
        real s;
        case (i)
            0:       a = 0.7853981633974483;
            1:       a = 0.4636476090008061;
            2:       a = 0.24497866312686414;
            3:       a = 0.12435499454676144;
            4:       a = 0.06241880999595735;
            5:       a = 0.031239833430268277;
            6:       a = 0.015623728620476831;
            7:       a = 0.007812341060101111;
            8:       a = 0.0039062301319669718;
            9:       a = 0.0019531225164788188;
            10:      a = 0.0009765621895593195;
            11:      a = 0.0004882812111948983;
            12:      a = 0.00024414062014936177;
            13:      a = 0.00012207031189367021;
            default: a = 2.0 ** (-i);   // atan(x) == x to well below 1 LSB here
        endcase
        s = (2.0 ** gp_z_width) / 6.283185307179586;
        return $rtoi(a * s + 0.5);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
`ifdef CORDIC_MAG_GAIN_COMP_EN
        S_GAIN,
`endif
        S_DONE
    } state_t;

    state_t                      state_q;
    logic [C_CW-1:0]             cnt_q;
    logic signed [C_W_INT-1:0]   x_q, y_q;
    logic [gp_z_width-1:0]       z_q;

    logic signed [C_W_INT-1:0]   x_in, y_in;
    logic signed [C_W_INT-1:0]   x_sh, y_sh;
    logic signed [C_W_INT-1:0]   x_rot, y_rot;
    logic [gp_z_width-1:0]       z_rot;
    logic [gp_z_width-1:0]       atan_tab [C_TAB];

    // Table padded to a power of two so any counter value indexes safely.
    for (genvar g = 0; g < C_TAB; g++) begin : g_atan
        localparam int C_AT = (g < gp_nr_iter) ? atan_entry(g) : 0;
        assign atan_tab[g] = gp_z_width'(C_AT);
    end

    // Sign-extend into the wide datapath, then move up into the guard bits.
    assign x_in = C_W_INT'(bus.i_x) <<< C_SH;
    assign y_in = C_W_INT'(bus.i_y) <<< C_SH;

    assign x_sh = x_q >>> cnt_q;
    assign y_sh = y_q >>> cnt_q;

    // One micro-rotation driving y toward zero; x/y use pre-update values.
    always_comb begin
        if (!y_q[C_W_INT-1]) begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + atan_tab[cnt_q];
        end else begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - atan_tab[cnt_q];
        end
    end

`ifdef CORDIC_MAG_GAIN_COMP_EN
    // 1/K scaled to 2^(gp_xy_width+1); always positive so fits W+2 signed bits.
    localparam int C_PW = C_W_INT + gp_xy_width + 2;
    localparam logic signed [gp_xy_width+1:0] C_GAIN_K =
        (gp_xy_width+2)'($rtoi(0.607252935 * (2.0 ** (gp_xy_width + 1)) + 0.5));

    logic signed [C_PW-1:0]    gain_prod;
    logic signed [C_W_INT-1:0] x_gain;

    assign gain_prod = C_PW'(x_q) * C_PW'(C_GAIN_K);
    assign x_gain    = C_W_INT'(gain_prod >>> (gp_xy_width + 1));
`endif

    // Control FSM and datapath registers; everything freezes while i_ena=0.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            bus.o_ready <= 1'b1;
            bus.o_valid <= 1'b0;
            bus.o_mag   <= '0;
            bus.o_phase <= '0;
        end else if (i_ena) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        if (x_in[C_W_INT-1]) begin
                            x_q <= -x_in;
                            y_q <= -y_in;
                            z_q <= C_PI;
                        end else begin
                            x_q <= x_in;
                            y_q <= y_in;
                            z_q <= '0;
                        end
                        cnt_q       <= '0;
                        bus.o_ready <= 1'b0;
                        state_q     <= S_ITER;
                    end
                end
                S_ITER: begin
                    x_q   <= x_rot;
                    y_q   <= y_rot;
                    z_q   <= z_rot;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_CW'(gp_nr_iter - 1)) begin
                        cnt_q <= '0;
`ifdef CORDIC_MAG_GAIN_COMP_EN
                        state_q <= S_GAIN;
`else
                        state_q <= S_DONE;
`endif
                    end
                end
`ifdef CORDIC_MAG_GAIN_COMP_EN
                S_GAIN: begin
                    x_q     <= x_gain;
                    state_q <= S_DONE;
                end
`endif
                S_DONE: begin
                    // First DONE cycle publishes; then hold until accepted.
                    if (!bus.o_valid) begin
                        bus.o_valid <= 1'b1;
                        bus.o_mag   <= (gp_xy_width+2)'(x_q >>> C_SH);
                        bus.o_phase <= z_q;
                    end else if (bus.i_ready) begin
                        bus.o_valid <= 1'b0;
                        bus.o_ready <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    bus.o_ready <= 1'b1;
                    bus.o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_mag_phase.sv
// tb_cordic_mag_phase: directed vectors with hand-computed magnitude/phase,
// latency, backpressure, clock-enable and mid-operation reset checks.
module tb_cordic_mag_phase;

    localparam int NI = 12;
    localparam int XW = 12;
    localparam int ZW = 12;

`ifdef CORDIC_MAG_GAIN_COMP_EN
    localparam int LAT   = NI + 2;
    localparam int M1000 = 1000;
    localparam int M2048 = 2896;
    localparam int M500  = 500;
`else
    localparam int LAT   = NI + 1;
    localparam int M1000 = 1647;
    localparam int M2048 = 4770;
    localparam int M500  = 823;
`endif

    logic i_clk;
    logic i_rst_an;
    logic i_ena;

    int n_chk = 0;
    int n_err = 0;

    cordic_mag_phase_if #(.gp_xy_width(XW), .gp_z_width(ZW)) bus ();

    cordic_mag_phase #(
        .gp_nr_iter (NI),
        .gp_xy_width(XW),
        .gp_z_width (ZW)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_an(i_rst_an),
        .i_ena   (i_ena),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    // Tolerance compare; modv != 0 wraps the difference (phase angles).
    task automatic chk(input string tag, input int obs, input int exp,
                       input int tol = 0, input int modv = 0);
        int d;
        d = obs - exp;
        if (modv != 0) begin
            d = d % modv;
            if (d >= modv / 2) d -= modv;
            if (d < -(modv / 2)) d += modv;
        end
        n_chk++;
        if (d > tol || d < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Feed one sample and wait for the result; lat counts enabled edges only.
    task automatic do_sample(input int xi, input int yi, input bit tog,
                             output int mag, output int ph, output int lat);
        bit got;
        @(negedge i_clk);
        chk("rdy_idle", int'(bus.o_ready), 1);
        bus.i_x     = XW'(xi);
        bus.i_y     = XW'(yi);
        bus.i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        chk("rdy_busy", int'(bus.o_ready), 0);
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge i_clk);
            if (tog) i_ena = c[0];
            @(posedge i_clk);
            #1;
            if (i_ena) lat++;
            if (bus.o_valid) got = 1'b1;
        end
        i_ena = 1'b1;
        chk("timeout", int'(got), 1);
        mag = int'(bus.o_mag);
        ph  = int'(bus.o_phase);
        if (bus.i_ready) begin
            @(posedge i_clk);
            #1;
            chk("vld_drop", int'(bus.o_valid), 0);
            chk("rdy_back", int'(bus.o_ready), 1);
        end
    endtask

    initial begin
        int m, p, l, m2, p2;

        i_rst_an    = 1'b0;
        i_ena       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_x     = '0;
        bus.i_y     = '0;
        #12;
        chk("rst_ready", int'(bus.o_ready), 1);
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_mag",   int'(bus.o_mag),   0);
        chk("rst_phase", int'(bus.o_phase), 0);
        @(negedge i_clk);
        i_rst_an = 1'b1;

        // Axis and quadrant vectors
        do_sample(1000, 0, 1'b0, m, p, l);
        chk("lat_1000_0",  l, LAT);
        chk("mag_1000_0",  m, M1000, 2);
        chk("ph_1000_0",   p, 0, 2, 4096);

        do_sample(0, 1000, 1'b0, m, p, l);
        chk("mag_0_1000",  m, M1000, 2);
        chk("ph_0_1000",   p, 1024, 2, 4096);

        do_sample(0, -1000, 1'b0, m, p, l);
        chk("ph_0_m1000",  p, -1024, 2, 4096);

        do_sample(-1000, 0, 1'b0, m, p, l);
        chk("mag_m1000_0", m, M1000, 2);
        chk("ph_m1000_0",  p, -2048, 2, 4096);

        // Most negative input on both axes
        do_sample(-2048, -2048, 1'b0, m, p, l);
        chk("mag_min",     m, M2048, 3);
        chk("ph_min",      p, -1536, 2, 4096);

        do_sample(0, 0, 1'b0, m, p, l);
        chk("mag_zero",    m, 0);

        // Same vector with and without a 50% clock enable
        do_sample(300, 400, 1'b0, m, p, l);
        chk("mag_300_400", m, M500, 3);
        chk("ph_300_400",  p, 604, 2, 4096);
        do_sample(300, 400, 1'b1, m2, p2, l);
        chk("ena_lat",     l, LAT);
        chk("ena_mag",     m2, m);
        chk("ena_phase",   p2, p);

        // Backpressure: result must hold, new samples ignored
        bus.i_ready = 1'b0;
        do_sample(1000, 0, 1'b0, m, p, l);
        chk("bp_lat", l, LAT);
        chk("bp_mag", m, M1000, 2);
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            bus.i_valid = 1'b1;
            bus.i_x     = XW'(-500);
            bus.i_y     = XW'(77);
            @(posedge i_clk);
            #1;
            chk("bp_valid", int'(bus.o_valid), 1);
            chk("bp_ready", int'(bus.o_ready), 0);
            chk("bp_mag",   int'(bus.o_mag),   m);
            chk("bp_phase", int'(bus.o_phase), p);
        end
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("bp_vld_drop", int'(bus.o_valid), 0);
        chk("bp_rdy_back", int'(bus.o_ready), 1);

        // Reset in the middle of the iterations
        @(negedge i_clk);
        bus.i_x     = XW'(1000);
        bus.i_y     = XW'(500);
        bus.i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        i_rst_an = 1'b0;
        #1;
        chk("mrst_valid", int'(bus.o_valid), 0);
        chk("mrst_mag",   int'(bus.o_mag),   0);
        chk("mrst_phase", int'(bus.o_phase), 0);
        chk("mrst_ready", int'(bus.o_ready), 1);
        @(negedge i_clk);
        i_rst_an = 1'b1;
        do_sample(300, 400, 1'b0, m, p, l);
        chk("post_rst_lat", l, LAT);
        chk("post_rst_ph",  p, 604, 2, 4096);
        chk("post_rst_mag", m, M500, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
